// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin front-end for a word-wide data memory.
// Sub-word stores run as read-modify-write; loads are lane-extracted and extended.
module dmem_access_ctrl #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic        req0_unsigned,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic        req1_unsigned,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] ADDR_LIM = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACC, WB, RESP} state_t;

  state_t      state_q;
  logic        last_q;
  logic        port_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic        err_q;

  logic        gnt0;
  logic        gnt1;
  logic        idle;
  logic        acc_err;
  logic        word_st;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_d;
  logic [31:0] merge_d;
  logic [31:0] wa;

  // With both ports valid the port that did not win last time is served.
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & ~gnt0;
  assign idle = ~rst & (state_q == IDLE);

  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;

  assign acc_err = (size_q == 2'b11)
                 | ((size_q == 2'b01) & addr_q[0])
                 | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
                 | (addr_q >= ADDR_LIM);

  assign word_st = we_q & (size_q == 2'b10);
  assign wa      = {addr_q[31:2], 2'b00};

  assign lb = mem_rd[{addr_q[1:0], 3'b000} +: 8];
  assign lh = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    ld_d = mem_rd;
    unique case (1'b1)
      size_q == 2'b00: ld_d = {{24{~uns_q & lb[7]}}, lb};
      size_q == 2'b01: ld_d = {{16{~uns_q & lh[15]}}, lh};
      default:         ld_d = mem_rd;
    endcase
  end

  always_comb begin
    merge_d = mem_rd;
    if (size_q == 2'b00)
      merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt0 | gnt1) begin
            port_q  <= gnt1;
            last_q  <= gnt1;
            we_q    <= gnt1 ? req1_we : req0_we;
            size_q  <= gnt1 ? req1_size : req0_size;
            uns_q   <= gnt1 ? req1_unsigned : req0_unsigned;
            addr_q  <= gnt1 ? req1_addr : req0_addr;
            wdata_q <= gnt1 ? req1_wdata : req0_wdata;
            err_q   <= 1'b0;
            data_q  <= '0;
            state_q <= ACC;
          end
        end
        ACC: begin
          if (acc_err) begin
            err_q   <= 1'b1;
            data_q  <= '0;
            state_q <= RESP;
          end else if (!we_q) begin
            data_q  <= ld_d;
            state_q <= RESP;
          end else if (word_st) begin
            data_q  <= '0;
            state_q <= RESP;
          end else begin
            data_q  <= merge_d;
            state_q <= WB;
          end
        end
        WB: begin
          data_q  <= '0;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic in_acc;
  logic in_wb;
  logic in_resp;

  assign in_acc  = ~rst & (state_q == ACC);
  assign in_wb   = ~rst & (state_q == WB);
  assign in_resp = ~rst & (state_q == RESP);

  assign mem_we = (in_acc & word_st & ~acc_err) | in_wb;
  assign mem_a  = (in_acc | in_wb) ? wa : '0;
  assign mem_wd = in_wb ? data_q
                : (in_acc & word_st & ~acc_err) ? wdata_q : '0;

  assign rsp0_valid = in_resp & ~port_q;
  assign rsp1_valid = in_resp & port_q;
  assign rsp0_rdata = rsp0_valid ? data_q : '0;
  assign rsp1_rdata = rsp1_valid ? data_q : '0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random traffic
// checked against a word-array reference of the memory.
module tb_dmem_access_ctrl;

  logic        clk = 0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_unsigned;
  logic [1:0]  req0_size;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_unsigned;
  logic [1:0]  req1_size;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        bd_we = 0;
  logic [5:0]  bd_a = 0;
  logic [31:0] bd_d = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_a] <= bd_d;
    else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  dmem_access_ctrl #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_we(req0_we), .req0_size(req0_size),
    .req0_unsigned(req0_unsigned), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_we(req1_we), .req1_size(req1_size),
    .req1_unsigned(req1_unsigned), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    bd_we = 1; bd_a = idx[5:0]; bd_d = v;
    @(posedge clk);
    #1 bd_we = 0;
    ref_mem[idx] = v;
  endtask

  task automatic set_port(input int p, input logic v, input logic we,
                          input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_size = sz;
      req0_unsigned = un; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_we = we; req1_size = sz;
      req1_unsigned = un; req1_addr = a; req1_wdata = wd;
    end
  endtask

  // Drives one request and gathers what the DUT does for it.
  task automatic do_req(input int p, input logic we, input logic [1:0] sz,
                        input logic un, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nwr, output int wr_at,
                        output logic stray);
    int t;
    rd = '0; er = 0; lat = -1; nwr = 0; wr_at = -1; stray = 0;
    @(negedge clk);
    set_port(p, 1, we, sz, un, a, wd);
    #1;
    t = 0;
    while (!(p == 1 ? req1_ready : req0_ready) && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 50) begin
      set_port(p, 0, 0, 0, 0, 0, 0);
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) set_port(p, 0, 0, 0, 0, 0, 0);
      if (mem_we) begin nwr++; wr_at = k; end
      if (mem_we && mem_a[1:0] != 2'b00) stray = 1;
      if ((p == 1 ? rsp0_valid : rsp1_valid)) stray = 1;
      if (req0_ready || req1_ready) stray = 1;
      if (p == 1 ? rsp1_valid : rsp0_valid) begin
        lat = k;
        rd = (p == 1) ? rsp1_rdata : rsp0_rdata;
        er = (p == 1) ? rsp1_err : rsp0_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [99:0] o;
    rst = 1;
    set_port(0, 1, 1, 2, 0, 32'h14, 32'h1);
    set_port(1, 1, 0, 2, 0, 32'h18, 32'h2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err,
         rsp1_err, mem_we, mem_a, mem_wd};
    total++;
    if (o !== '0) begin
      bad++; $display("FAIL reset_outputs got %h want 0", o);
    end
    o = {rsp0_rdata, rsp1_rdata};
    total++;
    if (o !== '0) begin
      bad++; $display("FAIL reset_rdata got %h want 0", o);
    end
    set_port(0, 0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0, 0);
    rst = 0;
  endtask

  task automatic test_load_word;
    logic [31:0] rd; logic er, st; int lat, nwr, wat;
    preload(5, 32'h0000_0011);
    do_req(0, 0, 2'b10, 0, 32'h14, 0, rd, er, lat, nwr, wat, st);
    total++;
    if ({rd, er, st} !== {32'h11, 1'b0, 1'b0} || lat != 2 || nwr != 0) begin
      bad++;
      $display("FAIL load_word got rd=%h err=%b lat=%0d wr=%0d st=%b want 11/0/2/0/0",
               rd, er, lat, nwr, st);
    end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd; logic er, st; int lat, nwr, wat;
    preload(8, 32'hAABB_CCDD);
    do_req(0, 1, 2'b00, 0, 32'h21, 32'h5A, rd, er, lat, nwr, wat, st);
    ref_mem[8] = 32'hAABB_5ADD;
    total++;
    if ({rd, er, st} !== 34'b0 || lat != 3 || nwr != 1 || wat != 2) begin
      bad++;
      $display("FAIL byte_store got rd=%h err=%b lat=%0d wr=%0d@%0d want 0/0/3/1@2",
               rd, er, lat, nwr, wat);
    end
    total++;
    if (mem[8] !== 32'hAABB_5ADD) begin
      bad++; $display("FAIL byte_store_mem got %h want aabb5add", mem[8]);
    end
  endtask

  task automatic test_subword_load;
    logic [31:0] rd; logic er, st; int lat, nwr, wat;
    do_req(0, 0, 2'b00, 0, 32'h20, 0, rd, er, lat, nwr, wat, st);
    total++;
    if (rd !== 32'hFFFF_FFDD || er !== 0 || lat != 2) begin
      bad++; $display("FAIL lb_signed got %h lat=%0d want ffffffdd lat=2", rd, lat);
    end
    do_req(1, 0, 2'b01, 1, 32'h22, 0, rd, er, lat, nwr, wat, st);
    total++;
    if (rd !== 32'h0000_AABB || er !== 0 || lat != 2) begin
      bad++; $display("FAIL lhu got %h lat=%0d want 0000aabb lat=2", rd, lat);
    end
  endtask

  task automatic test_arbitration;
    int g [$];
    logic both;
    both = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    set_port(0, 1, 0, 2'b10, 0, 32'h14, 0);
    set_port(1, 1, 0, 2'b10, 0, 32'h14, 0);
    for (int c = 0; c < 30 && g.size() < 3; c++) begin
      #1;
      if (req0_ready && req1_ready) both = 1;
      if (req0_ready) g.push_back(0);
      else if (req1_ready) g.push_back(1);
      @(negedge clk);
    end
    set_port(0, 0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    total++;
    if (both !== 0) begin
      bad++; $display("FAIL arb_two_readys got %b want 0", both);
    end
    total++;
    if (g.size() != 3 || g[0] != 0 || g[1] != 1 || g[2] != 0) begin
      bad++; $display("FAIL arb_order got n=%0d %p want 0 1 0", g.size(), g);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er, st; int lat, nwr, wat;
    logic [31:0] ea [4];
    logic [1:0]  es [4];
    ea = '{32'h06, 32'h03, 32'h1000, 32'h10};
    es = '{2'b10, 2'b01, 2'b00, 2'b11};
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1, es[i], 0, ea[i], 32'hDEAD_BEEF, rd, er, lat, nwr, wat, st);
      total++;
      if ({rd, er, st} !== {32'h0, 1'b1, 1'b0} || lat != 2 || nwr != 0) begin
        bad++;
        $display("FAIL err_%0d got rd=%h err=%b lat=%0d wr=%0d want 0/1/2/0",
                 i, rd, er, lat, nwr);
      end
    end
    total++;
    if (mem[0] !== ref_mem[0] || mem[1] !== ref_mem[1] || mem[4] !== ref_mem[4]) begin
      bad++; $display("FAIL err_mem got %h %h want %h %h",
                      mem[0], mem[1], ref_mem[0], ref_mem[1]);
    end
  endtask

  task automatic test_reset_wb;
    logic ok;
    preload(12, 32'h1234_5678);
    @(negedge clk);
    set_port(0, 1, 1, 2'b00, 0, 32'h30, 32'hEE);
    #1 ok = req0_ready;
    @(posedge clk);
    @(negedge clk);
    set_port(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if ((ok & mem_we) !== 1'b1) begin
      bad++; $display("FAIL rstwb_enter got rdy=%b we=%b want 1 1", ok, mem_we);
    end
    rst = 1;
    #1;
    total++;
    if (mem_we !== 0 || rsp0_valid !== 0) begin
      bad++; $display("FAIL rstwb_we got we=%b rsp=%b want 0 0", mem_we, rsp0_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    set_port(1, 1, 0, 2'b10, 0, 32'h30, 0);
    #1;
    total++;
    if ({rsp0_valid, rsp1_valid, mem_we, req1_ready} !== 4'b0001) begin
      bad++; $display("FAIL rstwb_idle got %b want 0001",
                      {rsp0_valid, rsp1_valid, mem_we, req1_ready});
    end
    set_port(1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (mem[12] !== 32'h1234_5678) begin
      bad++; $display("FAIL rstwb_mem got %h want 12345678", mem[12]);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, wd, w, xr, xw;
    logic er, st, we, un, xe;
    logic [1:0] sz;
    int lat, nwr, wat, p, off, xl, xn, sh;
    for (int i = 0; i < 80; i++) begin
      p  = $urandom % 2;
      we = $urandom % 2;
      un = $urandom % 2;
      sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      a  = ($urandom % 10 == 0) ? 32'h1000 + ($urandom % 32'h10000)
                                : 32'($urandom % 256);
      if ($urandom % 3 != 0) begin
        if (sz == 2'b10) a = a & ~32'h3;
        if (sz == 2'b01) a = a & ~32'h1;
      end
      wd = $urandom;
      xe = (sz == 3) || (sz == 1 && a % 2 != 0) ||
           (sz == 2 && a % 4 != 0) || (a >= 4096);
      off = int'(a % 4);
      xr = 0; xn = 0; xl = 2;
      if (!xe) begin
        w = ref_mem[a[7:2]];
        if (!we) begin
          if (sz == 0) begin
            xr = (w >> (8 * off)) & 32'hFF;
            if (!un && xr >= 128) xr = xr + 32'hFFFF_FF00;
          end else if (sz == 1) begin
            xr = (w >> (8 * (off / 2) * 2)) & 32'hFFFF;
            if (!un && xr >= 32768) xr = xr + 32'hFFFF_0000;
          end else xr = w;
        end else begin
          xn = 1;
          sh = (sz == 0) ? 8 * off : 16 * (off / 2);
          if (sz == 2) xw = wd;
          else if (sz == 0)
            xw = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
          else
            xw = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
          if (sz != 2) xl = 3;
          ref_mem[a[7:2]] = xw;
        end
      end
      do_req(p, we, sz, un, a, wd, rd, er, lat, nwr, wat, st);
      total++;
      if (rd !== xr || er !== xe || lat != xl || nwr != xn || st !== 0) begin
        bad++;
        $display("FAIL rand_%0d p%0d we%0d sz%0d a=%h got rd=%h e=%b l=%0d w=%0d s=%b want %h %b %0d %0d",
                 i, p, we, sz, a, rd, er, lat, nwr, st, xr, xe, xl, xn);
      end
    end
    for (int j = 0; j < 64; j++) begin
      total++;
      if (mem[j] !== ref_mem[j]) begin
        bad++; $display("FAIL rand_mem[%0d] got %h want %h", j, mem[j], ref_mem[j]);
      end
    end
  endtask

  initial begin
    rst = 1;
    set_port(0, 0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    test_reset();
    test_load_word();
    test_byte_store();
    test_subword_load();
    test_arbitration();
    test_errors();
    test_reset_wb();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
